// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage data-memory access controller:
//   - default RAM word-address width and rdy timeout
//   - access size codes (byte / half / word)
//   - controller state encoding
//   - alignment check helper shared by the controller
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W_DEF  = 11;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // 1 when the size code is illegal or the byte offset is not naturally aligned.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lo[0];
            SZ_WORD: err = (lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the pipeline request/response handshake and the word-RAM port.
//   slave  : the controller (accepts requests, drives the RAM strobes)
//   master : the environment (pipeline requester plus RAM)
// Request : req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata
// Response: rsp_valid (one-cycle pulse), rsp_rdata, rsp_err
// RAM     : mem_addr, mem_din, mem_nd, mem_we -> mem_dout, mem_rdy
// ----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;
    logic              mem_nd;
    logic              mem_we;
    logic              mem_rdy;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_din, mem_nd, mem_we,
        input  mem_dout, mem_rdy
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_din, mem_nd, mem_we,
        output mem_dout, mem_rdy
    );
endinterface

// File: rtl/mem_lane_unit.sv
// ----------------------------------------------------------------------------
// mem_lane_unit
// Purely combinational little-endian lane logic.
//   i_size/i_signed/i_lo : access size, sign-extend flag, byte offset addr[1:0]
//   i_word               : word read from RAM
//   i_wdata              : right-justified store data
//   o_rdata              : extracted load data, sign/zero extended
//   o_merged             : i_word with the addressed lanes replaced by i_wdata
// ----------------------------------------------------------------------------
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_word >> {i_lo, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_lo[1] ? i_word[31:16] : i_word[15:0];

    // Load extraction and store merge for the addressed lanes.
    always_comb begin
        o_rdata  = 32'h0000_0000;
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
                case (i_lo)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    2'd3:    o_merged[31:24] = i_wdata[7:0];
                    default: o_merged        = i_word;
                endcase
            end
            SZ_HALF: begin
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
                if (i_lo[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0]  = i_wdata[15:0];
                end
            end
            SZ_WORD: begin
                o_rdata  = i_word;
                o_merged = i_wdata;
            end
            default: begin
                o_rdata  = 32'h0000_0000;
                o_merged = i_word;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage initiator for a 2**ADDR_W x 32 word RAM. Takes one byte/half/word
// load or store per handshake, checks alignment/range, performs sub-word stores
// by read-modify-write and aborts with an error if mem_rdy does not arrive
// within TIMEOUT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_access_ctrl_if.slave (request, response and RAM port)
// All outputs are registered; strobes are loaded on the edge that enters
// READ/WRITE so they are high for exactly the cycle spent in that state.
// ----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_we;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [1:0]        r_lo;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_din;
    logic              r_mem_nd;
    logic              r_mem_we;

    logic              w_accept;
    logic              w_req_err;
    logic [31:0]       w_rdata;
    logic [31:0]       w_merged;

    assign w_accept  = bus.req_valid & r_req_ready;
    assign w_req_err = align_err(bus.req_size, bus.req_addr[1:0])
                     | ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);

    // Lane logic works on the latched request and the live RAM read data,
    // which is only consumed in RWAIT when mem_rdy is high.
    mem_lane_unit u_lane (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_lo     (r_lo),
        .i_word   (bus.mem_dout),
        .i_wdata  (r_wdata),
        .o_rdata  (w_rdata),
        .o_merged (w_merged)
    );

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;
    assign bus.mem_nd    = r_mem_nd;
    assign bus.mem_we    = r_mem_we;

    // Access FSM with registered request latch, strobes and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= 2'b00;
            r_lo        <= 2'b00;
            r_wdata     <= 32'h0000_0000;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_mem_addr  <= '0;
            r_mem_din   <= 32'h0000_0000;
            r_mem_nd    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            // Pulses default low; each state below raises them for one cycle.
            r_mem_nd    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_signed    <= bus.req_signed;
                        r_size      <= bus.req_size;
                        r_lo        <= bus.req_addr[1:0];
                        r_wdata     <= bus.req_wdata;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0000_0000;
                        end else begin
                            r_mem_addr <= bus.req_addr[ADDR_W+1:2];
                            if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                                r_state   <= ST_WRITE;
                                r_mem_we  <= 1'b1;
                                r_mem_din <= bus.req_wdata;
                            end else begin
                                // Loads and sub-word stores both need the old word.
                                r_state  <= ST_READ;
                                r_mem_nd <= 1'b1;
                            end
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (bus.mem_rdy) begin
                        if (r_we) begin
                            r_state   <= ST_WRITE;
                            r_mem_we  <= 1'b1;
                            r_mem_din <= w_merged;
                        end else begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= w_rdata;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // TIMEOUT cycles in RWAIT with no rdy: abort, never write.
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    r_state     <= ST_DONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0000_0000;
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0000_0000;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench: stimulus pushes the hand-computed expected response into a
// scoreboard queue; a negedge monitor pops and compares on rsp_valid and
// checks RAM strobes against the pending entry.
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_access_ctrl_if #(.ADDR_W(11)) bus();

    mem_access_ctrl #(.ADDR_W(11), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_nd;
        int          n_we;
        logic [10:0] maddr;
        logic [31:0] din;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nd_cnt = 0;
    int          we_cnt = 0;
    int          rsp_seen = 0;
    logic        both_seen = 1'b0;
    logic        mute = 1'b0;
    logic        stray = 1'b0;
    logic        ram_rdy = 1'b0;
    logic [31:0] ram_dout = 32'h0000_0000;
    logic [31:0] ram [0:2047];

    assign bus.mem_rdy  = ram_rdy | stray;
    assign bus.mem_dout = ram_dout;

    // Cycle counter used to measure accept-to-response latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Word RAM model: write on mem_we, read data + rdy one cycle after mem_nd.
    always @(posedge clk) begin
        ram_rdy <= 1'b0;
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_din;
        if (bus.mem_nd && !mute) begin
            ram_rdy  <= 1'b1;
            ram_dout <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (txn %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: strobe checks against the pending entry, response scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_nd && bus.mem_we) both_seen = 1'b1;
            if (bus.mem_nd) begin
                nd_cnt++;
                if (q.size() > 0) chk("nd_addr", q[0].id, 32'(bus.mem_addr), 32'(q[0].maddr));
            end
            if (bus.mem_we) begin
                we_cnt++;
                if (q.size() > 0) begin
                    chk("we_addr", q[0].id, 32'(bus.mem_addr), 32'(q[0].maddr));
                    chk("we_din", q[0].id, bus.mem_din, q[0].din);
                end
            end
            if (bus.rsp_valid) begin
                exp_t e;
                rsp_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
                end else begin
                    e = q.pop_front();
                    chk("rdata", e.id, bus.rsp_rdata, e.rdata);
                    chk("err", e.id, 32'(bus.rsp_err), 32'(e.err));
                    chk("latency", e.id, cyc - e.acc, e.lat);
                    chk("nd_count", e.id, nd_cnt, e.n_nd);
                    chk("we_count", e.id, we_cnt, e.n_we);
                    chk("ready_in_done", e.id, 32'(bus.req_ready), 32'd0);
                end
                nd_cnt = 0;
                we_cnt = 0;
            end
        end
    end

    // Issue one request (called at posedge+1) and wait for its response.
    task automatic issue(input int id, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input int n_nd, input int n_we, input logic [31:0] din);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) chk("ready_wait", id, 32'd0, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        // acc is the count before the accept edge, so the first cycle after
        // the accept edge measures as latency 1.
        e = '{id: id, rdata: exp_rdata, err: exp_err, lat: lat, n_nd: n_nd, n_we: n_we,
              maddr: addr[12:2], din: din, acc: cyc};
        q.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_size  = 2'($urandom_range(0, 3));
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            chk("rsp_timeout", id, 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 2048; i++) ram[i] = 32'h0000_0000;
        ram[2] = 32'h80FF_7F01;
        ram[3] = 32'h1122_3344;
        ram[5] = 32'hDEAD_BEEF;
        ram[7] = 32'h5566_7788;
        ram[9] = 32'h0102_0304;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 0, 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 0, 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 0, 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", 0, bus.rsp_rdata, 32'd0);
        chk("rst_mem_nd", 0, 32'(bus.mem_nd), 32'd0);
        chk("rst_mem_we", 0, 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 0, 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", 0, bus.mem_din, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        //     id we  size   sgn  addr          wdata          rdata          err  lat nd we din
        issue(1, 0, 2'b10, 0, 32'h0000_0014, 32'h0,        32'hDEAD_BEEF, 0, 3, 1, 0, 32'h0);
        issue(2, 0, 2'b00, 1, 32'h0000_000B, 32'h0,        32'hFFFF_FF80, 0, 3, 1, 0, 32'h0);
        issue(3, 0, 2'b00, 0, 32'h0000_000B, 32'h0,        32'h0000_0080, 0, 3, 1, 0, 32'h0);
        issue(4, 0, 2'b01, 1, 32'h0000_000A, 32'h0,        32'hFFFF_80FF, 0, 3, 1, 0, 32'h0);
        issue(5, 0, 2'b01, 1, 32'h0000_0008, 32'h0,        32'h0000_7F01, 0, 3, 1, 0, 32'h0);
        issue(6, 0, 2'b00, 1, 32'h0000_0009, 32'h0,        32'h0000_007F, 0, 3, 1, 0, 32'h0);
        issue(7, 1, 2'b00, 0, 32'h0000_000D, 32'h1234_56AA, 32'h0,       0, 4, 1, 1, 32'h1122_AA44);
        chk("ram3_after_rmw", 7, ram[3], 32'h1122_AA44);
        issue(8, 0, 2'b10, 0, 32'h0000_000C, 32'h0,        32'h1122_AA44, 0, 3, 1, 0, 32'h0);
        issue(9, 1, 2'b01, 0, 32'h0000_001E, 32'h0000_BEEF, 32'h0,       0, 4, 1, 1, 32'hBEEF_7788);
        issue(10, 0, 2'b10, 0, 32'h0000_001C, 32'h0,       32'hBEEF_7788, 0, 3, 1, 0, 32'h0);
        issue(11, 1, 2'b10, 0, 32'h0000_0018, 32'hCAFE_F00D, 32'h0,      0, 2, 0, 1, 32'hCAFE_F00D);
        chk("ram6_after_store", 11, ram[6], 32'hCAFE_F00D);
        // Error cases: one cycle, no strobes.
        issue(12, 0, 2'b01, 0, 32'h0000_0001, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
        issue(13, 0, 2'b10, 0, 32'h0000_0002, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
        issue(14, 0, 2'b11, 0, 32'h0000_0010, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
        issue(15, 0, 2'b10, 0, 32'h0000_2000, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
        issue(16, 1, 2'b00, 0, 32'h0000_2000, 32'h0000_0055, 32'h0,       1, 1, 0, 0, 32'h0);
        // Timeout: READ + 15 RWAIT cycles, then DONE.
        mute = 1'b1;
        issue(17, 0, 2'b10, 0, 32'h0000_0014, 32'h0,       32'h0,         1, 17, 1, 0, 32'h0);
        issue(18, 1, 2'b00, 0, 32'h0000_000C, 32'h0000_0099, 32'h0,       1, 17, 1, 0, 32'h0);
        mute = 1'b0;
        chk("ram3_after_timeout", 18, ram[3], 32'h1122_AA44);
        // Stray rdy while idle must be ignored.
        r0 = rsp_seen;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(posedge clk); #1;
        chk("stray_no_rsp", 19, rsp_seen, r0);
        chk("stray_ready", 19, 32'(bus.req_ready), 32'd1);
        issue(20, 0, 2'b10, 0, 32'h0000_0014, 32'h0,       32'hDEAD_BEEF, 0, 3, 1, 0, 32'h0);

        // Reset during WRITE of a word store.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0000_0024; bus.req_wdata = 32'hA5A5_A5A5;
        q.push_back('{id: 21, rdata: 32'h0, err: 1'b0, lat: 2, n_nd: 0, n_we: 1,
                      maddr: 11'd9, din: 32'hA5A5_A5A5, acc: cyc});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rst_mid_we_pre", 21, 32'(bus.mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_we_drop", 21, 32'(bus.mem_we), 32'd0);
        chk("rst_mid_nd_low", 21, 32'(bus.mem_nd), 32'd0);
        r0 = rsp_seen;
        @(posedge clk); #1;
        chk("rst_mid_ram9", 21, ram[9], 32'h0102_0304);
        @(negedge clk) rst_n = 1'b1;
        q.delete();
        nd_cnt = 0;
        we_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_ready", 21, 32'(bus.req_ready), 32'd1);
        chk("rst_mid_no_rsp", 21, rsp_seen, r0);
        issue(22, 0, 2'b10, 0, 32'h0000_0024, 32'h0,       32'h0102_0304, 0, 3, 1, 0, 32'h0);

        chk("nd_we_overlap", 0, 32'(both_seen), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
